// File: rtl/uart_rx_fifo.sv
// Receive buffer between the uart holding register and CPU MMIO.
// Ingest FSM acknowledges each byte into a first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clki,
  input  logic                  rst_in,
  input  logic [7:0]            rx_data,
  input  logic                  rx_new,
  output logic                  uart_ack,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [DEPTH];

  logic capture;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign capture = (state_q == IDLE) && rx_new;
  assign pop_ok  = pop && (count_q != '0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok = capture && ((count_q != FULL_CNT) || pop_ok);
  assign drop    = capture && !push_ok;

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (rx_new) state_d = ACK;
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!rx_new) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_ack = (state_q == ACK);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clki) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign ovf   = ovf_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Directed ingest/pop vectors; monitor checks every accepted pop.
module tb_uart_rx_fifo;

  logic       clki = 1'b0;
  logic       rst_in;
  logic [7:0] rx_data;
  logic       rx_new;
  logic       uart_ack;
  logic       pop;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovf;
  logic       clr_ovf;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clki     (clki),
    .rst_in   (rst_in),
    .rx_data  (rx_data),
    .rx_new   (rx_new),
    .uart_ack (uart_ack),
    .pop      (pop),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 clki = ~clki;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clki) begin
    if (rst_in && uart_ack) ack_cnt++;
    if (rst_in && pop && !empty) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pop", 1, 0);
      end else begin
        chk("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit do_pop,
                      input bit do_clr, input bit accept,
                      input int hold);
    @(posedge clki); #1;
    rx_data = b;
    rx_new  = 1'b1;
    pop     = do_pop;
    clr_ovf = do_clr;
    if (accept) exp_q.push_back(b);
    @(posedge clki); #1;
    pop     = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clki);
    chk("ack_pulse", int'(uart_ack), 1);
    repeat (hold) @(posedge clki);
    @(posedge clki); #1;
    rx_new = 1'b0;
    @(posedge clki); #1;
  endtask

  task automatic pop_one();
    @(posedge clki); #1;
    pop = 1'b1;
    @(posedge clki); #1;
    pop = 1'b0;
  endtask

  task automatic samp();
    @(negedge clki);
  endtask

  initial begin
    bit seen;
    rst_in  = 1'b0;
    rx_data = 8'h00;
    rx_new  = 1'b0;
    pop     = 1'b0;
    clr_ovf = 1'b0;
    #23;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ack", int'(uart_ack), 0);
    chk("rst_dout", int'(dout), 0);
    rst_in = 1'b1;

    send(8'h41, 1'b0, 1'b0, 1'b1, 3);
    samp();
    chk("one_ack", ack_cnt, 1);
    chk("one_count", int'(count), 1);
    chk("one_empty", int'(empty), 0);
    chk("one_dout", int'(dout), 8'h41);
    pop_one();

    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    samp();
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    chk("fill_ovf", int'(ovf), 0);
    send(8'hAA, 1'b0, 1'b0, 1'b0, 0);
    samp();
    chk("drop_ack_cnt", ack_cnt, 18);
    chk("drop_ovf", int'(ovf), 1);
    chk("drop_count", int'(count), 16);
    for (int i = 0; i < 16; i++) pop_one();
    samp();
    chk("drain_empty", int'(empty), 1);
    chk("drain_dout", int'(dout), 0);

    @(posedge clki); #1; clr_ovf = 1'b1;
    @(posedge clki); #1; clr_ovf = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 20; i++) send(8'h30 + 8'(i), 1'b1, 1'b0, 1'b1, 0);
    samp();
    chk("wrap_count", int'(count), 16);
    chk("wrap_full", int'(full), 1);
    chk("wrap_ovf", int'(ovf), 0);

    send(8'hE0, 1'b0, 1'b1, 1'b0, 0);
    samp();
    chk("clr_vs_drop", int'(ovf), 1);
    @(posedge clki); #1; clr_ovf = 1'b1;
    @(posedge clki); #1; clr_ovf = 1'b0;
    samp();
    chk("clr_alone", int'(ovf), 0);
    send(8'hE1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 11; i++) pop_one();
    samp();
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_ovf", int'(ovf), 1);

    @(posedge clki); #1;
    rx_data = 8'h99;
    rx_new  = 1'b1;
    @(posedge clki);
    @(negedge clki);
    chk("pre_rst_ack", int'(uart_ack), 1);
    #1 rst_in = 1'b0;
    #1;
    chk("async_ack", int'(uart_ack), 0);
    chk("async_count", int'(count), 0);
    chk("async_ovf", int'(ovf), 0);
    chk("async_empty", int'(empty), 1);
    exp_q.delete();
    @(posedge clki); #2;
    rst_in = 1'b1;
    exp_q.push_back(8'h99);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clki);
      if (uart_ack) seen = 1'b1;
    end
    chk("recapture_ack", int'(seen), 1);
    @(posedge clki); #1;
    rx_new = 1'b0;
    @(posedge clki); #1;
    samp();
    chk("recapture_count", int'(count), 1);
    pop_one();

    pop_one();
    samp();
    chk("empty_pop_count", int'(count), 0);
    chk("empty_pop_empty", int'(empty), 1);
    send(8'h55, 1'b0, 1'b0, 1'b1, 0);
    samp();
    chk("after_empty_dout", int'(dout), 8'h55);
    pop_one();
    samp();
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the uart core and the CPU's memory-mapped I/O decode at address 0x0001 (data) / 0x0002 (status).
- Drains each received byte from the uart's single-byte holding register into a first-word-fall-through FIFO.
- Acknowledges the byte back to the uart, so bursts arriving faster than software polls are not lost.
- The CPU pops bytes with a one-cycle strobe and sees count, full and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2^DEPTH_LOG2 bytes).

Ports:
- clki  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rx_data  input  8  byte from uart holding register; valid while rx_new=1.
- rx_new  input  1  uart "byte available" level flag; drops after uart_ack.
- uart_ack  output  1  one-cycle pulse to uart: holding register consumed (drives uart_read).
- pop  input  1  single-cycle CPU strobe: consume head byte (from read-done of address 0x0001).
- dout  output  8  head byte (first-word-fall-through); 8'h00 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
- ovf  output  1  sticky: a byte was dropped because the FIFO was full.
- clr_ovf  input  1  single-cycle strobe: clear ovf.

Behaviour:
- Reset (rst_in=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, ovf=0, uart_ack=0, FSM=IDLE. Storage contents are not reset. Reset mid-transfer discards all bytes and any pending ack.
- Ingest FSM, states IDLE, ACK, WAIT_CLR:
  - IDLE: if rx_new=1, capture rx_data and go to ACK. Capture means push if accepted, else set ovf.
  - ACK: uart_ack=1 for exactly this one cycle; go to WAIT_CLR unconditionally.
  - WAIT_CLR: stay until rx_new=0, then go to IDLE. A byte is never pushed twice for one rx_new assertion.
  - uart_ack is a registered Moore output (high only in ACK).
  - Minimum ingest period: 3 cycles per byte. The uart byte time (>=160 clki cycles) is far longer.
- Push acceptance (evaluated in IDLE with rx_new=1):
  - Accepted if count<DEPTH, or if count==DEPTH and a pop is accepted in the same cycle.
  - Otherwise the byte is dropped, ovf<=1, and the byte is still acknowledged.
- Pop:
  - Accepted when pop=1 and count>0.
  - pop on empty is ignored: no pointer, count or flag change.
- Pointers: DEPTH_LOG2 bits, increment mod DEPTH (natural wrap).
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
  - Updated at the same edge as the pointers.
- Flags:
  - empty = (count==0) and full = (count==DEPTH), both derived from the registered count.
- dout:
  - Combinational read of mem[rd_ptr] when !empty, forced 8'h00 when empty.
  - A pushed byte appears on dout the cycle after the push edge, when the FIFO was empty.
  - After an accepted pop, dout shows the next byte the following cycle.
- ovf:
  - Set on a dropped byte; cleared by clr_ovf.
  - If clr_ovf and a drop occur in the same cycle, set wins (ovf=1).
- Status mapping for the decoder: {12'b0, ovf, full, ~empty, 1'b0} is not generated here; the decoder concatenates these outputs.

Test Plan:
- Reset, then rx_data=8'h41 with rx_new held until ack -> exactly one uart_ack pulse 1 cycle after capture; next cycle count=1, empty=0, dout=8'h41; no second push while rx_new stays high.
- Push 8'h10..8'h1F (16 bytes, DEPTH_LOG2=4) -> full=1, count=16, ovf=0. Push 8'hAA -> uart_ack pulses, ovf=1, count stays 16. Pop 16 times -> dout sequence 8'h10..8'h1F, then empty=1, dout=8'h00.
- Full FIFO with a push coinciding with pop -> byte accepted, ovf stays 0, count stays 16, dout advances. Continue through 20 push/pop cycles -> pointer wrap preserves order.
- pop strobe while empty -> count=0, rd_ptr unchanged; a subsequent push of 8'h55 reads back 8'h55.
- ovf=1 with clr_ovf asserted in the same cycle as a dropped byte -> ovf remains 1; clr_ovf alone on a later cycle -> ovf=0.
- Assert rst_in=0 asynchronously mid-cycle in the ACK state with count=5 -> uart_ack, count and ovf go to 0 immediately; after release, FSM is in IDLE and re-captures if rx_new is still high.
